// File: rtl/network_link_buffer.sv
// Per-VC elastic buffer for one direction of a NoC link.
// Stop-and-go flow control upstream, round-robin re-injection downstream.
module network_link_buffer #(
   parameter int NetworkFlitWidth              = 16,
   parameter int NetworkFlitTypeWidth          = 2,
   parameter int NetworkBroadcastWidth         = 1,
   parameter int NetworkVirtualChannelIdWidth  = 1,
   parameter int NetworkNumberOfVirtualChannels = 2,
   parameter int BufferDepth                   = 4,
   parameter int GoSlack                       = 2,
   localparam int DataWidth = NetworkFlitWidth + NetworkFlitTypeWidth
                            + NetworkBroadcastWidth + NetworkVirtualChannelIdWidth
) (
   input  logic                                      clk_network_i,
   input  logic                                      rst_network_i,
   input  logic                                      network_valid_i,
   input  logic [DataWidth-1:0]                      network_data_i,
   output logic [NetworkNumberOfVirtualChannels-1:0] network_go_o,
   output logic                                      network_valid_o,
   output logic [DataWidth-1:0]                      network_data_o,
   input  logic [NetworkNumberOfVirtualChannels-1:0] network_go_i,
   output logic                                      overflow_o
);

   localparam int NumVc = NetworkNumberOfVirtualChannels;
   localparam int VcW   = NetworkVirtualChannelIdWidth;
   localparam int PtrW  = $clog2(BufferDepth);
   localparam int CntW  = $clog2(BufferDepth) + 1;
   localparam int IdxW  = (NumVc > 1) ? $clog2(NumVc) : 1;

   logic [DataWidth-1:0] mem [NumVc][BufferDepth];
   logic [PtrW-1:0]      wptr [NumVc];
   logic [PtrW-1:0]      rptr [NumVc];
   logic [CntW-1:0]      count [NumVc];
   logic [CntW-1:0]      occ_next [NumVc];

   logic [IdxW-1:0]  last_grant;
   logic [IdxW-1:0]  grant;
   logic [IdxW-1:0]  wr_vc;
   logic             grant_valid;
   logic             wr_en;
   logic             in_range;
   logic [NumVc-1:0] cand;
   logic [NumVc-1:0] go_next;

   assign wr_vc    = network_data_i[IdxW-1:0];
   assign in_range = int'(network_data_i[VcW-1:0]) < NumVc;

   // A VC competes when it holds a flit and downstream lets it go.
   always_comb begin
      cand = '0;
      for (int v = 0; v < NumVc; v++) begin
         cand[v] = (count[v] != '0) && network_go_i[v];
      end
   end

   // Round-robin pick starting just after the previous winner.
   always_comb begin
      logic [IdxW-1:0] idx;
      grant_valid = 1'b0;
      grant       = '0;
      idx         = '0;
      for (int i = 1; i <= NumVc; i++) begin
         idx = IdxW'((int'(last_grant) + i) % NumVc);
         if (!grant_valid && cand[idx]) begin
            grant_valid = 1'b1;
            grant       = idx;
         end
      end
   end

   // Accept a flit if its VC exists and has room, counting a same-cycle pop.
   always_comb begin
      wr_en = 1'b0;
      if (network_valid_i && in_range) begin
         if (count[wr_vc] < CntW'(BufferDepth)) begin
            wr_en = 1'b1;
         end else if (grant_valid && grant == wr_vc) begin
            wr_en = 1'b1;
         end
      end
   end

   // Next occupancy per VC and the go that follows from it.
   always_comb begin
      go_next = '0;
      for (int v = 0; v < NumVc; v++) begin
         occ_next[v] = count[v]
                     + CntW'(wr_en && wr_vc == IdxW'(v))
                     - CntW'(grant_valid && grant == IdxW'(v));
         go_next[v]  = (BufferDepth - int'(occ_next[v])) > GoSlack;
      end
   end

   // Flit storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk_network_i) begin
      if (!rst_network_i && wr_en) begin
         mem[wr_vc][wptr[wr_vc]] <= network_data_i;
      end
   end

   // Pointers, counters, output register, go and sticky overflow.
   always_ff @(posedge clk_network_i) begin
      if (rst_network_i) begin
         for (int v = 0; v < NumVc; v++) begin
            wptr[v]  <= '0;
            rptr[v]  <= '0;
            count[v] <= '0;
         end
         last_grant      <= IdxW'(NumVc - 1);
         network_go_o    <= '0;
         network_valid_o <= 1'b0;
         network_data_o  <= '0;
         overflow_o      <= 1'b0;
      end else begin
         for (int v = 0; v < NumVc; v++) begin
            count[v] <= occ_next[v];
         end
         if (wr_en) begin
            wptr[wr_vc] <= wptr[wr_vc] + 1'b1;
         end
         if (grant_valid) begin
            rptr[grant]    <= rptr[grant] + 1'b1;
            last_grant     <= grant;
            network_data_o <= mem[grant][rptr[grant]];
         end
         network_valid_o <= grant_valid;
         network_go_o    <= go_next;
         if (network_valid_i && !wr_en) begin
            overflow_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_network_link_buffer.sv
// Bench for network_link_buffer: fixed vectors, directed corner
// sequences and random traffic against a queue-based reference.
module tb_network_link_buffer;

   localparam int FW = 8;
   localparam int TW = 2;
   localparam int BW = 1;
   localparam int VW = 2;
   localparam int NV = 2;
   localparam int BD = 4;
   localparam int GS = 2;
   localparam int DW = FW + TW + BW + VW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          vi = 1'b0;
   logic [DW-1:0] di = '0;
   logic [NV-1:0] go_i = '0;
   logic [NV-1:0] go_o;
   logic          vo;
   logic [DW-1:0] dout;
   logic          ovf;

   always #5 clk = ~clk;

   network_link_buffer #(
      .NetworkFlitWidth(FW),
      .NetworkFlitTypeWidth(TW),
      .NetworkBroadcastWidth(BW),
      .NetworkVirtualChannelIdWidth(VW),
      .NetworkNumberOfVirtualChannels(NV),
      .BufferDepth(BD),
      .GoSlack(GS)
   ) dut (
      .clk_network_i(clk),
      .rst_network_i(rst),
      .network_valid_i(vi),
      .network_data_i(di),
      .network_go_o(go_o),
      .network_valid_o(vo),
      .network_data_o(dout),
      .network_go_i(go_i),
      .overflow_o(ovf)
   );

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [DW-1:0] mq [NV][$];
   int            mlast;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic [NV-1:0] m_go;
   logic          m_ovf;

   function automatic logic [DW-1:0] mk(input logic [7:0] p,
                                        input logic [1:0] vc);
      return {p, p[3:2], p[4], vc};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NV; k++) mq[k].delete();
      mlast   = NV - 1;
      m_valid = 1'b0;
      m_data  = '0;
      m_go    = '0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic [DW-1:0] d,
                             input logic [NV-1:0] g);
      int pick;
      int vc;
      logic acc;
      pick = -1;
      for (int i = 1; i <= NV; i++) begin
         int k;
         k = (mlast + i) % NV;
         if (pick < 0 && mq[k].size() > 0 && g[k]) pick = k;
      end
      acc = 1'b0;
      vc  = int'(d[VW-1:0]);
      if (v && vc < NV) begin
         if (mq[vc].size() < BD) acc = 1'b1;
         else if (pick == vc) acc = 1'b1;
      end
      if (pick >= 0) begin
         m_data  = mq[pick].pop_front();
         m_valid = 1'b1;
         mlast   = pick;
      end else begin
         m_valid = 1'b0;
      end
      if (acc) mq[vc].push_back(d);
      else if (v) m_ovf = 1'b1;
      for (int k = 0; k < NV; k++) m_go[k] = (BD - mq[k].size()) > GS;
   endtask

   task automatic tick(input logic v, input logic [DW-1:0] d,
                       input logic [NV-1:0] g);
      vi = v;
      di = d;
      go_i = g;
      if (rst) model_reset();
      else model_step(v, d, g);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string nm);
      chk({nm, ".valid"}, 32'(vo), 32'(m_valid));
      if (m_valid) chk({nm, ".data"}, 32'(dout), 32'(m_data));
      chk({nm, ".go"}, 32'(go_o), 32'(m_go));
      chk({nm, ".ovf"}, 32'(ovf), 32'(m_ovf));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0, '0, '0);
      tick(1'b0, '0, '0);
      chk("reset.valid", 32'(vo), 0);
      chk("reset.go", 32'(go_o), 0);
      chk("reset.ovf", 32'(ovf), 0);
      chk("reset.data", 32'(dout), 0);
      rst = 1'b0;
   endtask

   typedef struct {
      logic       v;
      logic [1:0] vc;
      logic [7:0] p;
      logic [1:0] g;
      logic       ev;
      logic [7:0] ep;
      logic [1:0] evc;
      logic [1:0] ego;
      logic       eovf;
   } vec_t;

   vec_t tbl [14];

   initial begin
      logic [1:0] seq [$];
      logic [7:0] outs [$];
      int         n1;
      logic       v;
      int         vc;
      logic [NV-1:0] g;

      tbl[0]  = '{1'b0, 2'd0, 8'h00, 2'b11, 1'b0, 8'h00, 2'd0, 2'b11, 1'b0};
      tbl[1]  = '{1'b1, 2'd0, 8'hA5, 2'b11, 1'b0, 8'h00, 2'd0, 2'b11, 1'b0};
      tbl[2]  = '{1'b0, 2'd0, 8'h00, 2'b11, 1'b1, 8'hA5, 2'd0, 2'b11, 1'b0};
      tbl[3]  = '{1'b0, 2'd0, 8'h00, 2'b11, 1'b0, 8'h00, 2'd0, 2'b11, 1'b0};
      tbl[4]  = '{1'b1, 2'd1, 8'h01, 2'b00, 1'b0, 8'h00, 2'd0, 2'b11, 1'b0};
      tbl[5]  = '{1'b1, 2'd1, 8'h02, 2'b00, 1'b0, 8'h00, 2'd0, 2'b01, 1'b0};
      tbl[6]  = '{1'b1, 2'd1, 8'h03, 2'b00, 1'b0, 8'h00, 2'd0, 2'b01, 1'b0};
      tbl[7]  = '{1'b1, 2'd1, 8'h04, 2'b00, 1'b0, 8'h00, 2'd0, 2'b01, 1'b0};
      tbl[8]  = '{1'b1, 2'd1, 8'h05, 2'b00, 1'b0, 8'h00, 2'd0, 2'b01, 1'b1};
      tbl[9]  = '{1'b0, 2'd0, 8'h00, 2'b10, 1'b1, 8'h01, 2'd1, 2'b01, 1'b1};
      tbl[10] = '{1'b0, 2'd0, 8'h00, 2'b10, 1'b1, 8'h02, 2'd1, 2'b01, 1'b1};
      tbl[11] = '{1'b0, 2'd0, 8'h00, 2'b10, 1'b1, 8'h03, 2'd1, 2'b11, 1'b1};
      tbl[12] = '{1'b0, 2'd0, 8'h00, 2'b10, 1'b1, 8'h04, 2'd1, 2'b11, 1'b1};
      tbl[13] = '{1'b0, 2'd0, 8'h00, 2'b10, 1'b0, 8'h00, 2'd0, 2'b11, 1'b1};

      // reset release, latency, go reaction and overflow
      do_reset();
      for (int i = 0; i < 14; i++) begin
         tick(tbl[i].v, mk(tbl[i].p, tbl[i].vc), tbl[i].g);
         chk($sformatf("vec%0d.valid", i), 32'(vo), 32'(tbl[i].ev));
         if (tbl[i].ev)
            chk($sformatf("vec%0d.data", i), 32'(dout),
                32'(mk(tbl[i].ep, tbl[i].evc)));
         chk($sformatf("vec%0d.go", i), 32'(go_o), 32'(tbl[i].ego));
         chk($sformatf("vec%0d.ovf", i), 32'(ovf), 32'(tbl[i].eovf));
      end

      // round-robin between two loaded VCs, then one VC blocked
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, mk(8'h10 + 8'(i), 2'd0), 2'b00);
         chk_model("rr_fill0");
         tick(1'b1, mk(8'h20 + 8'(i), 2'd1), 2'b00);
         chk_model("rr_fill1");
      end
      for (int i = 0; i < 8; i++) begin
         tick(1'b0, '0, 2'b11);
         chk_model("rr_drain");
         if (vo) seq.push_back(dout[1:0]);
      end
      chk("rr_count", 32'(seq.size()), 6);
      for (int i = 0; i < seq.size(); i++)
         chk($sformatf("rr_order%0d", i), 32'(seq[i]), 32'(i % 2));
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, mk(8'h30 + 8'(i), 2'd0), 2'b00);
         tick(1'b1, mk(8'h40 + 8'(i), 2'd1), 2'b00);
      end
      n1 = 0;
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, '0, 2'b10);
         chk_model("blk_drain");
         if (vo) begin
            chk("blk_vc", 32'(dout[1:0]), 1);
            n1++;
         end
      end
      chk("blk_count", 32'(n1), 2);

      // full VC with simultaneous push and pop
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, mk(8'(i), 2'd0), 2'b00);
         chk_model("full_fill");
      end
      for (int i = 4; i < 24; i++) begin
         tick(1'b1, mk(8'(i), 2'd0), 2'b01);
         chk_model("full_rw");
         chk("full_go0", 32'(go_o[0]), 0);
         if (vo) outs.push_back(dout[DW-1 -: 8]);
      end
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, '0, 2'b01);
         if (vo) outs.push_back(dout[DW-1 -: 8]);
      end
      chk("full_ovf", 32'(ovf), 0);
      chk("full_count", 32'(outs.size()), 24);
      for (int i = 0; i < outs.size(); i++)
         chk($sformatf("full_order%0d", i), 32'(outs[i]), 32'(i));

      // reset with buffered flits
      do_reset();
      for (int i = 0; i < 3; i++) tick(1'b1, mk(8'h50 + 8'(i), 2'd0), 2'b00);
      rst = 1'b1;
      tick(1'b1, mk(8'h60, 2'd0), 2'b11);
      chk_model("midrst");
      chk("midrst.data", 32'(dout), 0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1'b0, '0, 2'b11);
         chk("postrst.valid", 32'(vo), 0);
      end

      // random traffic against the reference model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 149) == 0);
         v  = ($urandom_range(0, 2) != 0);
         vc = ($urandom_range(0, 59) == 0) ? 3 : int'($urandom_range(0, 1));
         if (v && vc < NV && !go_o[vc] && $urandom_range(0, 5) != 0) v = 1'b0;
         g = '0;
         for (int k = 0; k < NV; k++) g[k] = ($urandom_range(0, 4) != 0);
         tick(v, mk(8'($urandom), 2'(vc)), g);
         chk_model("rand");
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
